// File: rtl/rv32i_writeback_unit_pkg.sv
// Shared definitions for the RV32I writeback stage: load funct3 codes,
// FSM state encoding and the SYSTEM/CSR decode helper.
// Latency: n/a (constants only). Backpressure: n/a.
package rv32i_writeback_unit_pkg;

  // Load funct3 encodings (LD/LWU only meaningful for XLEN=64)
  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LD  = 3'b011;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_LWU = 3'b110;

  // SYSTEM instructions with funct3==0 (ecall/ebreak/mret/wfi) produce no CSR read value
  localparam logic [2:0] FUNCT3_CSR_NONE = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_LOAD = 2'd1,
    ST_REDIRECT  = 2'd2
  } wb_state_e;

  // True when a SYSTEM instruction returns a CSR value to rd
  function automatic logic is_csr_op(input logic opcode_system, input logic [2:0] funct3);
    return opcode_system && (funct3 != FUNCT3_CSR_NONE);
  endfunction

endpackage

// File: rtl/rv32i_writeback_unit_load_extract.sv
// Load data extraction: selects byte/half/word lane from the aligned memory
// word and sign- or zero-extends it to XLEN.
// Latency: combinational. Backpressure: none.
// Ports:
//   i_funct3     load funct3
//   i_addr_lsb   byte offset within the XLEN word
//   i_data_load  raw aligned memory word
//   o_data       extended load result (raw word for unknown funct3)
module rv32i_writeback_unit_load_extract
  import rv32i_writeback_unit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int LSB_W = $clog2(XLEN/8)
) (
  input  logic [2:0]       i_funct3,
  input  logic [LSB_W-1:0] i_addr_lsb,
  input  logic [XLEN-1:0]  i_data_load,
  output logic [XLEN-1:0]  o_data
);

  // Halfword ignores lsb[0]; word ignores lsb[1:0] (always 0 for XLEN=32)
  logic [LSB_W-1:0] lsb_h;
  logic [LSB_W-1:0] lsb_w;
  logic [7:0]       byte_v;
  logic [15:0]      half_v;
  logic [31:0]      word_v;

  assign lsb_h  = i_addr_lsb & ~LSB_W'(1);
  assign lsb_w  = i_addr_lsb & ~LSB_W'(3);

  assign byte_v = 8'(i_data_load >> {i_addr_lsb, 3'b000});
  assign half_v = 16'(i_data_load >> {lsb_h, 3'b000});
  assign word_v = 32'(i_data_load >> {lsb_w, 3'b000});

  always_comb begin
    o_data = i_data_load;
    case (i_funct3)
      FUNCT3_LB:  o_data = XLEN'($signed(byte_v));
      FUNCT3_LBU: o_data = XLEN'(byte_v);
      FUNCT3_LH:  o_data = XLEN'($signed(half_v));
      FUNCT3_LHU: o_data = XLEN'(half_v);
      FUNCT3_LW:  o_data = XLEN'($signed(word_v));
      // Under XLEN=32 the zero-extended word equals the raw word, matching
      // the unknown-funct3 behaviour.
      FUNCT3_LWU: o_data = XLEN'(word_v);
      FUNCT3_LD:  o_data = i_data_load;
      default:    o_data = i_data_load;
    endcase
  end

endmodule

// File: rtl/rv32i_writeback_unit.sv
// Writeback stage: picks rd source (ALU/load/CSR), waits on slow load data, issues trap/mret PC redirects.
// Latency: 1 cycle from accept to registered basereg write / PC redirect pulse.
// Backpressure: o_stall (comb) holds upstream while load data is outstanding; o_flush on trap/mret.
// Optional: RV32I_WB_LOAD_TIMEOUT_EN enables the WAIT_LOAD timeout and o_load_fault.
// Ports:
//   i_clk/i_rst            clock, synchronous active-high reset
//   i_ce, i_funct3, i_opcode_load, i_opcode_system, i_wr_rd, i_rd_addr, i_rd   instruction in
//   i_data_load, i_load_ack, i_addr_lsb                                        load return
//   i_csr_out, i_go_to_trap, i_return_from_trap, i_trap_address, i_return_address
//   o_wr_rd, o_rd_addr, o_rd    registered basereg write port
//   o_next_pc, o_change_pc      registered redirect
//   o_stall, o_flush            combinational pipeline control
//   o_load_fault                registered load-timeout pulse
module rv32i_writeback_unit
  import rv32i_writeback_unit_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int REG_ADDR_W   = 5,
  parameter int LOAD_TIMEOUT = 255
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_ce,
  input  logic [2:0]                 i_funct3,
  input  logic                       i_opcode_load,
  input  logic                       i_opcode_system,
  input  logic                       i_wr_rd,
  input  logic [REG_ADDR_W-1:0]      i_rd_addr,
  input  logic [XLEN-1:0]            i_rd,
  input  logic [XLEN-1:0]            i_data_load,
  input  logic                       i_load_ack,
  input  logic [$clog2(XLEN/8)-1:0]  i_addr_lsb,
  input  logic [XLEN-1:0]            i_csr_out,
  input  logic                       i_go_to_trap,
  input  logic                       i_return_from_trap,
  input  logic [XLEN-1:0]            i_trap_address,
  input  logic [XLEN-1:0]            i_return_address,
  output logic                       o_wr_rd,
  output logic [REG_ADDR_W-1:0]      o_rd_addr,
  output logic [XLEN-1:0]            o_rd,
  output logic [XLEN-1:0]            o_next_pc,
  output logic                       o_change_pc,
  output logic                       o_stall,
  output logic                       o_flush,
  output logic                       o_load_fault
);

  localparam int LSB_W = $clog2(XLEN/8);

  wb_state_e state_q, state_d;

  logic                  redirect_req;
  logic                  accept;
  logic                  load_timeout;
  logic [XLEN-1:0]       load_val;
  logic [XLEN-1:0]       wb_val;
  logic                  wr_rd_d;

  logic                  wr_rd_q;
  logic [REG_ADDR_W-1:0] rd_addr_q;
  logic [XLEN-1:0]       rd_q;
  logic [XLEN-1:0]       next_pc_q;
  logic                  change_pc_q;

  assign redirect_req = i_go_to_trap || i_return_from_trap;

  rv32i_writeback_unit_load_extract #(
    .XLEN  (XLEN),
    .LSB_W (LSB_W)
  ) u_load_extract (
    .i_funct3    (i_funct3),
    .i_addr_lsb  (i_addr_lsb),
    .i_data_load (i_data_load),
    .o_data      (load_val)
  );

  // ---------------------------------------------------------------- FSM: state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------- FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (i_ce && redirect_req) begin
          state_d = ST_REDIRECT;
        end else if (i_ce && i_opcode_load && !i_load_ack) begin
          state_d = ST_WAIT_LOAD;
        end
      end
      ST_WAIT_LOAD: begin
        // A trap abandons the outstanding load outright
        if (redirect_req) begin
          state_d = ST_REDIRECT;
        end else if (i_load_ack || load_timeout) begin
          state_d = ST_IDLE;
        end
      end
      ST_REDIRECT: state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- FSM: outputs
  // accept marks the cycle an instruction retires through this stage
  // (write or redirect). A load entering WAIT_LOAD is not accepted yet.
  always_comb begin
    o_stall = 1'b0;
    o_flush = 1'b0;
    accept  = 1'b0;
    if (!i_rst) begin
      case (state_q)
        ST_IDLE: begin
          if (i_ce) begin
            if (redirect_req) begin
              o_flush = 1'b1;
              accept  = 1'b1;
            end else if (i_opcode_load && !i_load_ack) begin
              o_stall = 1'b1;
            end else begin
              accept  = 1'b1;
            end
          end
        end
        ST_WAIT_LOAD: begin
          if (redirect_req) begin
            o_flush = 1'b1;
            accept  = 1'b1;
          end else if (i_load_ack) begin
            accept  = 1'b1;
          end else if (!load_timeout) begin
            // On timeout the stall drops so upstream moves past the faulted load
            o_stall = 1'b1;
          end
        end
        ST_REDIRECT: o_flush = 1'b1;
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------- writeback data path
  assign wb_val  = i_opcode_load ? load_val
                 : (is_csr_op(i_opcode_system, i_funct3) ? i_csr_out : i_rd);

  // x0 is never written; redirects suppress the write
  assign wr_rd_d = accept && !redirect_req && i_wr_rd && (i_rd_addr != '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_rd_q     <= 1'b0;
      rd_addr_q   <= '0;
      rd_q        <= '0;
      next_pc_q   <= '0;
      change_pc_q <= 1'b0;
    end else begin
      wr_rd_q     <= wr_rd_d;
      change_pc_q <= accept && redirect_req;
      if (wr_rd_d) begin
        rd_addr_q <= i_rd_addr;
        rd_q      <= wb_val;
      end
      if (accept && redirect_req) begin
        next_pc_q <= i_go_to_trap ? i_trap_address : i_return_address;
      end
    end
  end

  assign o_wr_rd     = wr_rd_q;
  assign o_rd_addr   = rd_addr_q;
  assign o_rd        = rd_q;
  assign o_next_pc   = next_pc_q;
  assign o_change_pc = change_pc_q;

  // ---------------------------------------------------------------- load timeout
`ifdef RV32I_WB_LOAD_TIMEOUT_EN
  localparam int CNT_W = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOAD_TIMEOUT - 1);

  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             load_fault_q;

  // tmo_cnt_q counts WAIT_LOAD cycles already spent; the LOAD_TIMEOUT-th
  // WAIT_LOAD cycle without ack is the fault cycle. Ack or trap in that
  // cycle takes precedence.
  assign load_timeout = (state_q == ST_WAIT_LOAD) && !i_load_ack && !redirect_req
                     && (tmo_cnt_q == CNT_LAST);

  always_comb begin
    tmo_cnt_d = '0;
    if (state_q == ST_WAIT_LOAD && state_d == ST_WAIT_LOAD) begin
      tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tmo_cnt_q    <= '0;
      load_fault_q <= 1'b0;
    end else begin
      tmo_cnt_q    <= tmo_cnt_d;
      load_fault_q <= load_timeout;
    end
  end

  assign o_load_fault = load_fault_q;
`else
  // Without the timeout the stage waits for load data indefinitely
  logic [31:0] unused_load_timeout;
  assign unused_load_timeout = 32'(LOAD_TIMEOUT);
  assign load_timeout        = 1'b0;
  assign o_load_fault        = 1'b0;
`endif

endmodule

// File: tb/tb_rv32i_writeback_unit.sv
// Bench for rv32i_writeback_unit: directed cases plus randomized instruction
// stream checked against a transaction-level reference model.
// Latency: n/a. Backpressure: n/a.
module tb_rv32i_writeback_unit;

  localparam int TB_TO = 4;
`ifdef RV32I_WB_LOAD_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        i_ce;
  logic [2:0]  i_funct3;
  logic        i_opcode_load;
  logic        i_opcode_system;
  logic        i_wr_rd;
  logic [4:0]  i_rd_addr;
  logic [31:0] i_rd;
  logic [31:0] i_data_load;
  logic        i_load_ack;
  logic [1:0]  i_addr_lsb;
  logic [31:0] i_csr_out;
  logic        i_go_to_trap;
  logic        i_return_from_trap;
  logic [31:0] i_trap_address;
  logic [31:0] i_return_address;
  logic        o_wr_rd;
  logic [4:0]  o_rd_addr;
  logic [31:0] o_rd;
  logic [31:0] o_next_pc;
  logic        o_change_pc;
  logic        o_stall;
  logic        o_flush;
  logic        o_load_fault;

  int n_tests = 0;
  int n_fail  = 0;

  rv32i_writeback_unit #(
    .XLEN         (32),
    .REG_ADDR_W   (5),
    .LOAD_TIMEOUT (TB_TO)
  ) dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_ce               (i_ce),
    .i_funct3           (i_funct3),
    .i_opcode_load      (i_opcode_load),
    .i_opcode_system    (i_opcode_system),
    .i_wr_rd            (i_wr_rd),
    .i_rd_addr          (i_rd_addr),
    .i_rd               (i_rd),
    .i_data_load        (i_data_load),
    .i_load_ack         (i_load_ack),
    .i_addr_lsb         (i_addr_lsb),
    .i_csr_out          (i_csr_out),
    .i_go_to_trap       (i_go_to_trap),
    .i_return_from_trap (i_return_from_trap),
    .i_trap_address     (i_trap_address),
    .i_return_address   (i_return_address),
    .o_wr_rd            (o_wr_rd),
    .o_rd_addr          (o_rd_addr),
    .o_rd               (o_rd),
    .o_next_pc          (o_next_pc),
    .o_change_pc        (o_change_pc),
    .o_stall            (o_stall),
    .o_flush            (o_flush),
    .o_load_fault       (o_load_fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected rd value straight from the ISA load/CSR/ALU rules
  function automatic logic [31:0] ref_wb(input bit ld, input bit sys, input logic [2:0] f3,
                                         input logic [31:0] alu, input logic [31:0] raw,
                                         input logic [1:0] lsb, input logic [31:0] csr);
    int v;
    int off;
    if (ld) begin
      case (f3)
        3'd0: begin v = (raw >> (8 * int'(lsb))) & 255; if (v >= 128) v -= 256; return 32'(v); end
        3'd4: begin v = (raw >> (8 * int'(lsb))) & 255; return 32'(v); end
        3'd1: begin
          off = 16 * (int'(lsb) / 2);
          v = (raw >> off) & 65535; if (v >= 32768) v -= 65536; return 32'(v);
        end
        3'd5: begin off = 16 * (int'(lsb) / 2); v = (raw >> off) & 65535; return 32'(v); end
        default: return raw;
      endcase
    end
    if (sys && f3 != 3'd0) return csr;
    return alu;
  endfunction

  task automatic drive_idle_inputs();
    i_ce = 1'b0; i_go_to_trap = 1'b0; i_return_from_trap = 1'b0; i_load_ack = 1'b0;
  endtask

  // One instruction: ack arrives ack_delay cycles after presentation;
  // redir_at >= 0 injects a trap (redir_trap) or mret at that cycle.
  task automatic run_instr(input bit ld, input bit sys, input logic [2:0] f3, input bit wr,
                           input logic [4:0] rda, input logic [31:0] alu, input logic [31:0] raw,
                           input logic [1:0] lsb, input logic [31:0] csr, input int ack_delay,
                           input int redir_at, input bit redir_trap, input logic [31:0] target);
    logic [31:0] exp_val;
    bit exp_wr;
    exp_val = ref_wb(ld, sys, f3, alu, raw, lsb, csr);
    exp_wr  = wr && (rda != 5'd0);
    i_ce = 1'b1; i_opcode_load = ld; i_opcode_system = sys; i_funct3 = f3; i_wr_rd = wr;
    i_rd_addr = rda; i_rd = alu; i_data_load = raw; i_addr_lsb = lsb; i_csr_out = csr;
    i_trap_address   = redir_trap ? target : $urandom;
    i_return_address = redir_trap ? $urandom : target;
    for (int c = 0; c <= ack_delay; c++) begin
      bit redir_now;
      bit to_now;
      redir_now = (c == redir_at);
      to_now    = TO_EN && ld && !redir_now && (c == TB_TO) && (c < ack_delay);
      i_load_ack         = ld ? (c == ack_delay) : 1'($urandom);
      i_go_to_trap       = redir_now && redir_trap;
      i_return_from_trap = redir_now && !redir_trap;
      @(negedge clk);
      check_eq("flush", o_flush, redir_now);
      check_eq("stall", o_stall, !redir_now && !to_now && ld && (c < ack_delay));
      @(posedge clk); #1;
      check_eq("change_pc", o_change_pc, redir_now);
      check_eq("load_fault", o_load_fault, to_now);
      if (redir_now) begin
        check_eq("next_pc", o_next_pc, target);
        check_eq("wr_rd_redirect", o_wr_rd, 0);
        drive_idle_inputs();
        @(negedge clk);
        check_eq("flush_hold", o_flush, 1);
        @(posedge clk); #1;
        check_eq("change_pc_pulse", o_change_pc, 0);
        check_eq("wr_rd_after_redirect", o_wr_rd, 0);
        return;
      end
      if (to_now) begin
        check_eq("wr_rd_timeout", o_wr_rd, 0);
        drive_idle_inputs();
        @(posedge clk); #1;
        check_eq("load_fault_pulse", o_load_fault, 0);
        return;
      end
      if (c == ack_delay) begin
        check_eq("wr_rd", o_wr_rd, exp_wr);
        if (exp_wr) begin
          check_eq("rd_addr", o_rd_addr, rda);
          check_eq("rd", o_rd, exp_val);
        end
        return;
      end
      check_eq("wr_rd_wait", o_wr_rd, 0);
    end
  endtask

  // i_ce low in IDLE: nothing must happen regardless of other inputs
  task automatic run_idle();
    i_ce = 1'b0; i_opcode_load = 1'($urandom); i_opcode_system = 1'($urandom);
    i_wr_rd = 1'b1; i_rd_addr = 5'($urandom_range(1, 31)); i_load_ack = 1'($urandom);
    i_go_to_trap = 1'($urandom); i_return_from_trap = 1'($urandom);
    @(negedge clk);
    check_eq("idle_flush", o_flush, 0);
    check_eq("idle_stall", o_stall, 0);
    @(posedge clk); #1;
    check_eq("idle_wr_rd", o_wr_rd, 0);
    check_eq("idle_change_pc", o_change_pc, 0);
    drive_idle_inputs();
  endtask

  initial begin
    bit          ld, sys, wr, rt;
    logic [2:0]  f3;
    int          k, ad, ri;
    logic [4:0]  ra;
    rst = 1'b1;
    i_ce = 1'b1; i_funct3 = 3'd0; i_opcode_load = 1'b1; i_opcode_system = 1'b0;
    i_wr_rd = 1'b1; i_rd_addr = 5'd3; i_rd = 32'h0; i_data_load = 32'h0; i_load_ack = 1'b0;
    i_addr_lsb = 2'd0; i_csr_out = 32'h0; i_go_to_trap = 1'b1; i_return_from_trap = 1'b0;
    i_trap_address = 32'h40; i_return_address = 32'h80;
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("rst_stall", o_stall, 0);
    check_eq("rst_flush", o_flush, 0);
    @(posedge clk); #1;
    check_eq("rst_wr_rd", o_wr_rd, 0);
    check_eq("rst_rd_addr", o_rd_addr, 0);
    check_eq("rst_rd", o_rd, 0);
    check_eq("rst_next_pc", o_next_pc, 0);
    check_eq("rst_change_pc", o_change_pc, 0);
    check_eq("rst_load_fault", o_load_fault, 0);
    drive_idle_inputs();
    rst = 1'b0;
    run_idle();

    // Directed cases
    run_instr(0, 0, 3'd0, 1, 5'd5, 32'h12345678, 32'h0, 2'd0, 32'h0, 0, -1, 0, 32'h0);
    run_instr(1, 0, 3'd0, 1, 5'd6, 32'h0, 32'h80FF7F01, 2'd3, 32'h0, 0, -1, 0, 32'h0);
    run_instr(1, 0, 3'd5, 1, 5'd7, 32'h0, 32'h80FF7F01, 2'd2, 32'h0, 0, -1, 0, 32'h0);
    run_instr(1, 0, 3'd1, 1, 5'd8, 32'h0, 32'h80FF7F01, 2'd3, 32'h0, 0, -1, 0, 32'h0);
    run_instr(1, 0, 3'd2, 1, 5'd9, 32'h0, 32'hCAFEF00D, 2'd1, 32'h0, 3, -1, 0, 32'h0);
    run_instr(1, 0, 3'd2, 1, 5'd9, 32'h0, 32'h11111111, 2'd0, 32'h0, 5, 2, 1, 32'h100);
    run_instr(0, 0, 3'd0, 1, 5'd0, 32'hDEADBEEF, 32'h0, 2'd0, 32'h0, 0, -1, 0, 32'h0);
    run_instr(0, 1, 3'd0, 0, 5'd0, 32'h0, 32'h0, 2'd0, 32'h0, 0, 0, 0, 32'h2000);
    run_instr(0, 1, 3'd2, 1, 5'd10, 32'h5555, 32'h0, 2'd0, 32'hA5A5A5A5, 0, -1, 0, 32'h0);
    run_instr(1, 0, 3'd4, 1, 5'd11, 32'h0, 32'h89ABCDEF, 2'd1, 32'h0, 8, -1, 0, 32'h0);
    run_instr(1, 0, 3'd0, 1, 5'd12, 32'h0, 32'h000000FE, 2'd0, 32'h0, TB_TO, -1, 0, 32'h0);
    run_idle();

    // Randomized instruction stream
    for (int n = 0; n < 300; n++) begin
      k   = $urandom_range(0, 9);
      ld  = (k < 5);
      sys = (k == 5) || (k == 6);
      wr  = ($urandom_range(0, 5) != 0);
      rt  = 1'($urandom);
      f3  = 3'($urandom);
      ad  = ld ? (($urandom_range(0, 3) == 0) ? $urandom_range(3, 7) : $urandom_range(0, 2)) : 0;
      ra  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      ri  = ($urandom_range(0, 6) == 0) ? $urandom_range(0, ad) : -1;
      run_instr(ld, sys, f3, wr, ra, $urandom, $urandom, 2'($urandom), $urandom, ad, ri, rt,
                $urandom);
      if ($urandom_range(0, 3) == 0) run_idle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety net in case the stimulus ever stops advancing
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

endmodule
